fi_pipe_inject: RTL and testbench
=================================

// Module: fi_pipe_inject
// PURPOSE
//  Parametrised fault-injection delay pipeline, successor of the 1-bit fiapp flop chain.
//  Each stage is a WIDTH-bit register, DEPTH stages deep, with a registered inverted tap of stage 0.
//  An on-chip controller injects bit-flip / stuck-at-0 / stuck-at-1 faults into one selected stage.
//  Injection has a programmable delay and duration.
//  Used as the DUT for fault-injection and signal-of-interest (SOI) observation experiments.
// PARAMETERS
//  WIDTH   8   data width of every stage
//  DEPTH   3   number of pipeline stages (>=2)
//  CNT_W   8   width of fi_delay / fi_len counters
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            asynchronous, active-high reset
//  din        in   WIDTH        pipeline input
//  enable     in   1            load enable for stage 0 only
//  stage_q    out  DEPTH*WIDTH  all stage registers, stage k at [k*WIDTH +: WIDTH]
//  dout_inv   out  WIDTH        registered ~stage_q[0]
//  fi_arm     in   1            start request, sampled only in IDLE
//  fi_mode    in   2            fi_mode_e: FLIP=0, STUCK0=1, STUCK1=2, 3 illegal
//  fi_stage   in   $clog2(DEPTH) target stage index
//  fi_mask    in   WIDTH        target bits
//  fi_delay   in   CNT_W        idle cycles before injection
//  fi_len     in   CNT_W        injection cycles (0 treated as 1)
//  fi_busy    out  1            controller not IDLE
//  fi_active  out  1            state == ACTIVE
//  fi_done    out  1            1-cycle pulse at end of injection
//  fi_err     out  1            1-cycle pulse: arm rejected
//  soi_tap    out  WIDTH        stage_q of latched target stage (post-fault value)
// BEHAVIOUR
//  Reset: all stages, dout_inv, counters and latched config = 0; state IDLE.
//   All flag outputs = 0; soi_tap = 0.
//  Reset mid-operation aborts any injection immediately; no fi_done pulse follows.
//  Nominal datapath, every edge:
//   - stage0 <= enable ? din : stage0;
//   - stage k <= stage k-1 (k>=1);
//   - dout_inv <= ~stage0 (old value).
//  Fault: while state==ACTIVE, the next value of stage S (latched fi_stage) becomes f(nominal):
//   - FLIP:   nominal ^ mask
//   - STUCK0: nominal & ~mask
//   - STUCK1: nominal | mask
//   Applies even when stage 0 holds (enable=0).
//   The corrupted value then propagates normally to downstream stages.
//  FSM states IDLE, WAIT, ACTIVE, DONE.
//   - IDLE: fi_arm=1 at edge T.
//     - If fi_stage>=DEPTH or fi_mode==3: fi_err=1 for cycle after T; stay IDLE.
//     - Else latch stage/mode/mask; cnt<=fi_delay; go to WAIT.
//   - WAIT: cnt==0 -> ACTIVE with cnt<=max(fi_len,1)-1; else cnt--.
//   - ACTIVE: cnt==0 -> DONE; else cnt--.
//   - DONE: fi_done=1 for this one cycle; -> IDLE.
//  Latency: first corrupted update at edge T+D+2; last at T+D+1+L (L=max(len,1)).
//   fi_done is high during the cycle after edge T+D+1+L.
//  fi_arm outside IDLE (including in DONE) is ignored.
//   Input config changes after T are ignored.
//  fi_busy = state!=IDLE.
//  soi_tap selects by the latched stage; it reads stage 0 until the first valid arm.
//  Counters never wrap: cnt is only decremented when nonzero.
// STRUCTURE
//  Package fi_pkg:
//   - fi_mode_e (2-bit)
//   - fi_state_e (IDLE/WAIT/ACTIVE/DONE)
//   - function fi_apply(mode, mask, val) returning the faulted value
//  Sub-module fi_inject_ctrl: FSM, counters, config latch, flag outputs.
//  Top: stage array, dout_inv, fault mux, soi_tap mux.
// TESTING (WIDTH=8, DEPTH=3, T = edge sampling fi_arm)
//  1 Pipe: reset, then din=A5, enable=1:
//    - stage0=A5 @e1, stage1=A5 @e2, stage2=A5 @e3; dout_inv=5A @e2.
//    - enable=0 with din=3C: stage0 holds A5.
//  2 Flip: din=10 constant; arm stage=1, mask=01, delay=0, len=1:
//    - stage1=11 @T+2 only; stage2=11 @T+3; fi_done high after T+2.
//  3 Stuck1: din=00; stage=2, mask=F0, delay=3, len=4:
//    - stage2=F0 @T+5..T+8, then 00; fi_busy high T+1..T+9.
//    - soi_tap tracks stage2.
//  4 Reject: arm with stage=3 or mode=3:
//    - fi_err pulse after T; busy stays 0; stage values nominal.
//  5 Abort: assert reset during ACTIVE:
//    - all outputs 0 immediately, IDLE; no fi_done pulse after release.
//  6 Re-arm: pulse fi_arm during WAIT and during DONE with different config:
//    - both ignored; original fault applied unchanged.

Source files
------------

// File: rtl/fi_pkg.sv
// Shared types and the fault transfer function for the fault-injection pipeline.
// Imported by the controller and the pipeline top.
package fi_pkg;

    typedef enum logic [1:0] {
        FLIP      = 2'd0,
        STUCK0    = 2'd1,
        STUCK1    = 2'd2,
        MODE_RSVD = 2'd3
    } fi_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } fi_state_e;

    // Packages cannot be parameterised, so the fault function works on a wide word.
    // Callers zero-extend into it and truncate the result back to their own width.
    localparam int FI_MAX_W = 64;
    typedef logic [FI_MAX_W-1:0] fi_word_t;

    function automatic fi_word_t fi_apply(fi_mode_e mode, fi_word_t mask, fi_word_t val);
        case (mode)
            FLIP:    return val ^ mask;
            STUCK0:  return val & ~mask;
            STUCK1:  return val | mask;
            default: return val;
        endcase
    endfunction

endpackage

// File: rtl/fi_inject_ctrl.sv
// Injection controller: arm/reject decision, config latch, delay/length counters, and flags.
// The flags are registered alongside the state, so they always match the state register.
module fi_inject_ctrl
    import fi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = 8,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fi_arm,
    input  logic [1:0]       fi_mode,
    input  logic [SEL_W-1:0] fi_stage,
    input  logic [WIDTH-1:0] fi_mask,
    input  logic [CNT_W-1:0] fi_delay,
    input  logic [CNT_W-1:0] fi_len,
    output logic [SEL_W-1:0] sel,
    output fi_mode_e         mode,
    output logic [WIDTH-1:0] mask,
    output logic             fi_busy,
    output logic             fi_active,
    output logic             fi_done,
    output logic             fi_err
);

    fi_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;

    // NOTE: every register here is written with <=, so each branch sees the pre-edge
    // values of its neighbours and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            sel       <= '0;
            mode      <= FLIP;
            mask      <= '0;
            fi_busy   <= 1'b0;
            fi_active <= 1'b0;
            fi_done   <= 1'b0;
            fi_err    <= 1'b0;
        end else begin
            fi_err  <= 1'b0;
            fi_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fi_arm) begin
                        if (int'(fi_stage) >= DEPTH || fi_mode == 2'd3) begin
                            fi_err <= 1'b1;
                        end else begin
                            sel     <= fi_stage;
                            mode    <= fi_mode_e'(fi_mode);
                            mask    <= fi_mask;
                            len_q   <= fi_len;
                            cnt     <= fi_delay;
                            state   <= WAIT;
                            fi_busy <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        // A zero length still injects for one cycle.
                        cnt       <= (len_q == '0) ? '0 : len_q - CNT_W'(1);
                        state     <= ACTIVE;
                        fi_active <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        fi_active <= 1'b0;
                        fi_done   <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    fi_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    fi_busy   <= 1'b0;
                    fi_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fi_pipe_inject.sv
// Fault-injection delay pipeline: DEPTH stages of WIDTH bits, an inverted tap of stage 0,
// and a controller that corrupts the next value of one latched stage while ACTIVE.
module fi_pipe_inject
    import fi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           din,
    input  logic                       enable,
    output logic [DEPTH*WIDTH-1:0]     stage_q,
    output logic [WIDTH-1:0]           dout_inv,
    input  logic                       fi_arm,
    input  logic [1:0]                 fi_mode,
    input  logic [$clog2(DEPTH)-1:0]   fi_stage,
    input  logic [WIDTH-1:0]           fi_mask,
    input  logic [CNT_W-1:0]           fi_delay,
    input  logic [CNT_W-1:0]           fi_len,
    output logic                       fi_busy,
    output logic                       fi_active,
    output logic                       fi_done,
    output logic                       fi_err,
    output logic [WIDTH-1:0]           soi_tap
);

    localparam int SEL_W = $clog2(DEPTH);

    logic [WIDTH-1:0] stage   [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [SEL_W-1:0] sel;
    fi_mode_e         mode;
    logic [WIDTH-1:0] mask;

    fi_inject_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .SEL_W (SEL_W)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .fi_arm    (fi_arm),
        .fi_mode   (fi_mode),
        .fi_stage  (fi_stage),
        .fi_mask   (fi_mask),
        .fi_delay  (fi_delay),
        .fi_len    (fi_len),
        .sel       (sel),
        .mode      (mode),
        .mask      (mask),
        .fi_busy   (fi_busy),
        .fi_active (fi_active),
        .fi_done   (fi_done),
        .fi_err    (fi_err)
    );

    // NOTE: every element of stage_d gets its nominal value before the fault override,
    // so no path through this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        stage_d[0] = enable ? din : stage[0];
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (fi_active && sel == SEL_W'(k)) begin
                stage_d[k] = WIDTH'(fi_apply(mode, fi_word_t'(mask), fi_word_t'(stage_d[k])));
            end
        end
    end

    // NOTE: the stage array is a handful of flops rather than a RAM, so it takes the
    // asynchronous reset like any other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
            dout_inv <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= stage_d[k];
            end
            dout_inv <= ~stage[0];
        end
    end

    always_comb begin
        soi_tap = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sel == SEL_W'(k)) begin
                soi_tap = stage[k];
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_pack
        assign stage_q[k*WIDTH +: WIDTH] = stage[k];
    end

endmodule

// File: tb/tb_fi_pipe_inject.sv
// Scoreboard bench for fi_pipe_inject: stimulus queues hand-computed expectations tagged
// with the clock edge they belong to; a negedge monitor pops and compares them.
module tb_fi_pipe_inject;
    import fi_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  din = '0;
    logic        enable = 1'b0;
    logic [23:0] stage_q;
    logic [7:0]  dout_inv;
    logic        fi_arm = 1'b0;
    logic [1:0]  fi_mode = '0;
    logic [1:0]  fi_stage = '0;
    logic [7:0]  fi_mask = '0;
    logic [7:0]  fi_delay = '0;
    logic [7:0]  fi_len = '0;
    logic        fi_busy, fi_active, fi_done, fi_err;
    logic [7:0]  soi_tap;

    fi_pipe_inject #(.WIDTH(8), .DEPTH(3), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .enable    (enable),
        .stage_q   (stage_q),
        .dout_inv  (dout_inv),
        .fi_arm    (fi_arm),
        .fi_mode   (fi_mode),
        .fi_stage  (fi_stage),
        .fi_mask   (fi_mask),
        .fi_delay  (fi_delay),
        .fi_len    (fi_len),
        .fi_busy   (fi_busy),
        .fi_active (fi_active),
        .fi_done   (fi_done),
        .fi_err    (fi_err),
        .soi_tap   (soi_tap)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef enum int {S_ST0, S_ST1, S_ST2, S_INV, S_BUSY, S_ACT, S_DONE, S_ERR, S_SOI} sig_e;
    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s @edge %0d: got %02h expected %02h", name, edge_cnt, act, exp_v);
        end
    endtask

    function automatic logic [7:0] probe(sig_e s);
        case (s)
            S_ST0:   return stage_q[7:0];
            S_ST1:   return stage_q[15:8];
            S_ST2:   return stage_q[23:16];
            S_INV:   return dout_inv;
            S_BUSY:  return {7'd0, fi_busy};
            S_ACT:   return {7'd0, fi_active};
            S_DONE:  return {7'd0, fi_done};
            S_ERR:   return {7'd0, fi_err};
            default: return soi_tap;
        endcase
    endfunction

    // Monitor: after each edge, compare every expectation tagged with that edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < edge_cnt) begin
                checks++;
                failures++;
                $display("FAIL %s: expectation for edge %0d never sampled", sb[i].name, sb[i].cyc);
                sb.delete(i);
            end else if (sb[i].cyc == edge_cnt) begin
                check(sb[i].name, probe(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int cyc, input sig_e s, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = s;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // One-cycle arm pulse; returns T, the edge that sampled it (not yet sampled by the monitor).
    task automatic arm_pulse(input logic [1:0] st, input logic [1:0] md, input logic [7:0] mk,
                             input logic [7:0] dl, input logic [7:0] ln, output int t);
        fi_stage = st;
        fi_mode  = md;
        fi_mask  = mk;
        fi_delay = dl;
        fi_len   = ln;
        fi_arm   = 1'b1;
        tick(1);
        fi_arm = 1'b0;
        t = edge_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int e;

        // Reset state
        tick(3);
        reset = 1'b0;
        e = edge_cnt;
        expect_at(e, S_ST0, 8'h00, "rst_stage0");
        expect_at(e, S_ST1, 8'h00, "rst_stage1");
        expect_at(e, S_ST2, 8'h00, "rst_stage2");
        expect_at(e, S_INV, 8'h00, "rst_dout_inv");
        expect_at(e, S_BUSY, 8'h00, "rst_busy");
        expect_at(e, S_SOI, 8'h00, "rst_soi");

        // 1: nominal pipe and stage-0 hold
        din = 8'hA5;
        enable = 1'b1;
        e = edge_cnt;
        expect_at(e + 1, S_ST0, 8'hA5, "pipe_stage0_e1");
        expect_at(e + 1, S_INV, 8'hFF, "pipe_inv_e1");
        expect_at(e + 2, S_ST1, 8'hA5, "pipe_stage1_e2");
        expect_at(e + 2, S_INV, 8'h5A, "pipe_inv_e2");
        expect_at(e + 3, S_ST2, 8'hA5, "pipe_stage2_e3");
        expect_at(e + 2, S_ST0, 8'hA5, "hold_stage0_e2");
        expect_at(e + 3, S_ST0, 8'hA5, "hold_stage0_e3");
        tick(1);
        din = 8'h3C;
        enable = 1'b0;
        tick(3);

        // 2: flip bit 0 of stage 1 for one cycle
        din = 8'h10;
        enable = 1'b1;
        tick(3);
        arm_pulse(2'd1, 2'd0, 8'h01, 8'd0, 8'd1, t);
        expect_at(t, S_BUSY, 8'h01, "flip_busy_T");
        expect_at(t + 1, S_ACT, 8'h01, "flip_active_T1");
        expect_at(t + 1, S_ST1, 8'h10, "flip_stage1_T1");
        expect_at(t + 2, S_ST1, 8'h11, "flip_stage1_T2");
        expect_at(t + 2, S_SOI, 8'h11, "flip_soi_T2");
        expect_at(t + 3, S_ST1, 8'h10, "flip_stage1_T3");
        expect_at(t + 3, S_ST2, 8'h11, "flip_stage2_T3");
        expect_at(t + 4, S_ST2, 8'h10, "flip_stage2_T4");
        expect_at(t + 1, S_DONE, 8'h00, "flip_done_T1");
        expect_at(t + 2, S_DONE, 8'h01, "flip_done_T2");
        expect_at(t + 3, S_DONE, 8'h00, "flip_done_T3");
        expect_at(t + 3, S_BUSY, 8'h00, "flip_busy_T3");
        tick(6);

        // 3: stuck-at-1 upper nibble of stage 2, delay 3, length 4
        din = 8'h00;
        tick(3);
        arm_pulse(2'd2, 2'd2, 8'hF0, 8'd3, 8'd4, t);
        for (int k = 0; k <= 8; k++) expect_at(t + k, S_BUSY, 8'h01, "stuck1_busy");
        expect_at(t + 9, S_BUSY, 8'h00, "stuck1_busy_T9");
        expect_at(t + 4, S_ST2, 8'h00, "stuck1_stage2_T4");
        for (int k = 5; k <= 8; k++) expect_at(t + k, S_ST2, 8'hF0, "stuck1_stage2");
        expect_at(t + 9, S_ST2, 8'h00, "stuck1_stage2_T9");
        expect_at(t + 4, S_SOI, 8'h00, "stuck1_soi_T4");
        expect_at(t + 6, S_SOI, 8'hF0, "stuck1_soi_T6");
        expect_at(t + 9, S_SOI, 8'h00, "stuck1_soi_T9");
        expect_at(t + 3, S_ACT, 8'h00, "stuck1_active_T3");
        expect_at(t + 4, S_ACT, 8'h01, "stuck1_active_T4");
        expect_at(t + 8, S_ACT, 8'h00, "stuck1_active_T8");
        expect_at(t + 7, S_DONE, 8'h00, "stuck1_done_T7");
        expect_at(t + 8, S_DONE, 8'h01, "stuck1_done_T8");
        expect_at(t + 9, S_DONE, 8'h00, "stuck1_done_T9");
        tick(11);

        // 6: re-arm during WAIT and DONE is ignored
        din = 8'hFF;
        tick(3);
        arm_pulse(2'd0, 2'd1, 8'h0F, 8'd2, 8'd2, t);
        expect_at(t + 3, S_ST0, 8'hFF, "rearm_stage0_T3");
        expect_at(t + 4, S_ST0, 8'hF0, "rearm_stage0_T4");
        expect_at(t + 5, S_ST0, 8'hF0, "rearm_stage0_T5");
        expect_at(t + 6, S_ST0, 8'hFF, "rearm_stage0_T6");
        expect_at(t + 7, S_ST0, 8'hFF, "rearm_stage0_T7");
        expect_at(t + 5, S_ST1, 8'hF0, "rearm_stage1_T5");
        expect_at(t + 6, S_ST1, 8'hF0, "rearm_stage1_T6");
        expect_at(t + 7, S_ST1, 8'hFF, "rearm_stage1_T7");
        expect_at(t + 8, S_ST1, 8'hFF, "rearm_stage1_T8");
        expect_at(t + 9, S_ST1, 8'hFF, "rearm_stage1_T9");
        expect_at(t + 5, S_SOI, 8'hF0, "rearm_soi_T5");
        expect_at(t + 5, S_DONE, 8'h01, "rearm_done_T5");
        expect_at(t + 6, S_BUSY, 8'h00, "rearm_busy_T6");
        expect_at(t + 7, S_BUSY, 8'h00, "rearm_busy_T7");
        expect_at(t + 3, S_ERR, 8'h00, "rearm_err_T3");
        expect_at(t + 7, S_ERR, 8'h00, "rearm_err_T7");
        tick(1);
        fi_stage = 2'd1;
        fi_mode  = 2'd0;
        fi_mask  = 8'hFF;
        fi_delay = 8'd0;
        fi_len   = 8'd5;
        fi_arm   = 1'b1;
        tick(1);
        fi_arm = 1'b0;
        tick(3);
        fi_arm = 1'b1;
        tick(1);
        fi_arm = 1'b0;
        tick(6);

        // 4: rejected arms (bad stage, bad mode)
        arm_pulse(2'd3, 2'd0, 8'hFF, 8'd0, 8'd1, t);
        expect_at(t, S_ERR, 8'h01, "rej_stage_err_T");
        expect_at(t + 1, S_ERR, 8'h00, "rej_stage_err_T1");
        expect_at(t, S_BUSY, 8'h00, "rej_stage_busy_T");
        expect_at(t + 1, S_BUSY, 8'h00, "rej_stage_busy_T1");
        expect_at(t + 2, S_ST0, 8'hFF, "rej_stage_stage0");
        expect_at(t + 2, S_ST1, 8'hFF, "rej_stage_stage1");
        tick(3);
        arm_pulse(2'd0, 2'd3, 8'hFF, 8'd0, 8'd1, t);
        expect_at(t, S_ERR, 8'h01, "rej_mode_err_T");
        expect_at(t, S_BUSY, 8'h00, "rej_mode_busy_T");
        expect_at(t + 1, S_ACT, 8'h00, "rej_mode_active_T1");
        expect_at(t + 1, S_SOI, 8'hFF, "rej_mode_soi_T1");
        expect_at(t + 2, S_ST0, 8'hFF, "rej_mode_stage0");
        tick(3);

        // 5: reset during ACTIVE aborts with no later done pulse
        din = 8'h00;
        tick(3);
        arm_pulse(2'd1, 2'd0, 8'hFF, 8'd0, 8'd10, t);
        expect_at(t + 1, S_ACT, 8'h01, "abort_active_T1");
        expect_at(t + 1, S_ST1, 8'h00, "abort_stage1_T1");
        tick(2);
        reset = 1'b1;
        e = edge_cnt;
        expect_at(e, S_ST0, 8'h00, "abort_stage0");
        expect_at(e, S_ST1, 8'h00, "abort_stage1");
        expect_at(e, S_ST2, 8'h00, "abort_stage2");
        expect_at(e, S_INV, 8'h00, "abort_inv");
        expect_at(e, S_BUSY, 8'h00, "abort_busy");
        expect_at(e, S_ACT, 8'h00, "abort_active");
        expect_at(e, S_DONE, 8'h00, "abort_done");
        expect_at(e, S_ERR, 8'h00, "abort_err");
        expect_at(e, S_SOI, 8'h00, "abort_soi");
        tick(2);
        reset = 1'b0;
        e = edge_cnt;
        for (int k = 1; k <= 10; k++) begin
            expect_at(e + k, S_DONE, 8'h00, "abort_no_done");
            expect_at(e + k, S_BUSY, 8'h00, "abort_no_busy");
        end
        expect_at(e + 1, S_ST1, 8'h00, "abort_stage1_post");
        expect_at(e + 1, S_INV, 8'hFF, "abort_inv_post");
        expect_at(e + 1, S_SOI, 8'h00, "abort_soi_post");
        tick(12);

        tick(2);
        for (int i = 0; i < sb.size(); i++) begin
            checks++;
            failures++;
            $display("FAIL %s: expectation for edge %0d left in scoreboard", sb[i].name, sb[i].cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
